decode_queue: RTL and testbench
===============================

# decode_queue

Multi-issue decode buffer between instruction fetch and issue. Accepts up to FETCH_WIDTH raw instructions per cycle, decodes each through a `decoder` instance, and stores the decoded result and PC in a circular queue. It then presents up to ISSUE_WIDTH in-order entries per cycle to issue under a count-based consume handshake. Optionally it keeps a MIPS control-flow instruction from issuing without its delay slot.

## Interface
- FETCH_WIDTH, 2: instructions offered by fetch per cycle (≥1).
- ISSUE_WIDTH, 2: head entries presented to issue per cycle (1..DEPTH).
- DEPTH, 8: queue entries; power of two, ≥ FETCH_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  discard all queued entries and this cycle's fetch group.
- fetch_valid  in  FETCH_WIDTH  per-slot valid; only the contiguous run of ones starting at bit 0 is used.
- fetch_instr  in  FETCH_WIDTH×32  raw instruction words.
- fetch_pc  in  FETCH_WIDTH×32  PC of each slot.
- fetch_ready  out  1  queue can take a full fetch group this cycle.
- issue_valid  out  ISSUE_WIDTH  head entry k is presentable; thermometer-coded from bit 0.
- issue_instr  out  ISSUE_WIDTH×decoded_instr_t  decoded head entries.
- issue_pc  out  ISSUE_WIDTH×32  PCs of head entries.
- issue_num  in  $clog2(ISSUE_WIDTH+1)  entries consumed this cycle.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Enqueue count n_in is the number of consecutive ones in fetch_valid from bit 0. Examples: 2'b11 gives 2, 2'b10 gives 0.
- A group is accepted when fetch_ready=1 and n_in>0 and flush=0. Slots 0..n_in-1 are decoded and written at tail..tail+n_in-1 (mod DEPTH), and tail advances by n_in.
- fetch_ready = (DEPTH − count ≥ FETCH_WIDTH). It is computed from registered count only; a same-cycle dequeue does not free space for that cycle's enqueue.
- issue_valid[k] = (k < count), further masked by the pairing rule when enabled. issue_instr[k] and issue_pc[k] come from entry head+k (mod DEPTH).
- Dequeue: head advances by issue_num and entries are freed. issue_num greater than the number of asserted issue_valid bits is illegal; the bench asserts on it.
- Next count = count + accepted n_in − issue_num. Enqueue and dequeue may coincide.
- Flush has priority over everything else: head, tail and count go to 0, the fetch group is dropped and issue_num is ignored.
- Entries of dequeued slots are not cleared; stale contents are permitted where issue_valid=0.

## Timing
- Reset values: count=0, head=tail=0, issue_valid=0, fetch_ready=1, issue_instr/issue_pc don't-care.
- An instruction accepted in cycle t appears on issue_valid no earlier than cycle t+1, at one register stage of latency.
- The decode path is combinational from fetch_instr into the queue write port. Issue outputs are combinational from queue state; there is no path from issue_num to issue outputs.
- Pointer wrap is modulo DEPTH with no bubble. Full is count==DEPTH; empty is count==0.
- Reset asserted mid-operation clears the queue immediately, asynchronously; nothing is enqueued while rst=1.

## Configuration
- DECODE_DELAY_SLOT_PAIR_EN defined: for each k, if entry head+k has is_controlflow=1, issue_valid[k] and all higher bits are forced low when either of these holds:
  - k+1 ≥ count (delay slot not yet queued);
  - k = ISSUE_WIDTH−1 with ISSUE_WIDTH>1 (delay slot would miss this group).
  - A held entry becomes slot 0 on a later cycle. With ISSUE_WIDTH=1 only the presence rule applies.
- Undefined: no masking. issue_valid[k] = (k < count).

## Test plan
- Reset, then fetch_valid=2'b11 with addu and or at PC 0x100/0x104 → count=0, fetch_ready=1 during reset; cycle t+1: issue_valid=2'b11, op OP_ADDU/OP_OR, issue_pc 0x100/0x104.
- Fill: issue_num=0, offer 4 groups of 2 → count=8, fetch_ready=0; a 5th group is not accepted; issue_num=2 with a simultaneous offer → that offer is refused, count=6.
- Wrap: 20 cycles of enqueue 2 and dequeue 2 → count stays 2; PCs issue strictly increasing across the pointer wrap.
- Flush with count=5 and a valid fetch group → next cycle count=0, issue_valid=0; the dropped group's PCs never appear.
- fetch_valid=2'b10 → nothing is enqueued and count is unchanged.
- With DECODE_DELAY_SLOT_PAIR_EN, queue [addu, beq] with count=2 → issue_valid=2'b01. After issue_num=1 and enqueue of the delay slot → issue_valid=2'b11 with beq in slot 0. Without the macro → issue_valid=2'b11 immediately.

Source files
------------

// File: rtl/decode_queue_if.sv
// Decoded-instruction package and the fetch/issue bundle of decode_queue.
// The queue takes the slave modport; the fetch/issue side takes master.
package decode_queue_pkg;
  localparam logic [3:0] OP_INVALID = 4'd0;
  localparam logic [3:0] OP_SLL     = 4'd1;
  localparam logic [3:0] OP_ADDU    = 4'd2;
  localparam logic [3:0] OP_SUBU    = 4'd3;
  localparam logic [3:0] OP_AND     = 4'd4;
  localparam logic [3:0] OP_OR      = 4'd5;
  localparam logic [3:0] OP_SLT     = 4'd6;
  localparam logic [3:0] OP_ADDIU   = 4'd7;
  localparam logic [3:0] OP_LW      = 4'd8;
  localparam logic [3:0] OP_SW      = 4'd9;
  localparam logic [3:0] OP_BEQ     = 4'd10;
  localparam logic [3:0] OP_BNE     = 4'd11;
  localparam logic [3:0] OP_J       = 4'd12;
  localparam logic [3:0] OP_JAL     = 4'd13;
  localparam logic [3:0] OP_JR      = 4'd14;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        is_controlflow;
  } decoded_instr_t;
endpackage

// Handshakes: a fetch group is taken on a rising edge when fetch_ready=1,
// flush=0 and fetch_valid[0]=1 (the leading run of ones is taken). Issue
// entries are consumed by the count issue_num, which must never exceed the
// number of asserted issue_valid bits; flush overrides both sides.
interface decode_queue_if
  import decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
);
  logic                                  flush;
  logic [FETCH_WIDTH-1:0]                fetch_valid;
  logic [FETCH_WIDTH-1:0][31:0]          fetch_instr;
  logic [FETCH_WIDTH-1:0][31:0]          fetch_pc;
  logic                                  fetch_ready;
  logic [ISSUE_WIDTH-1:0]                issue_valid;
  decoded_instr_t [ISSUE_WIDTH-1:0]      issue_instr;
  logic [ISSUE_WIDTH-1:0][31:0]          issue_pc;
  logic [$clog2(ISSUE_WIDTH+1)-1:0]      issue_num;
  logic [$clog2(DEPTH+1)-1:0]            count;

  modport master (
    output flush, fetch_valid, fetch_instr, fetch_pc, issue_num,
    input  fetch_ready, issue_valid, issue_instr, issue_pc, count
  );

  modport slave (
    input  flush, fetch_valid, fetch_instr, fetch_pc, issue_num,
    output fetch_ready, issue_valid, issue_instr, issue_pc, count
  );
endinterface

// File: rtl/decode_queue.sv
// MIPS decoder plus circular multi-issue decode queue between fetch and issue.
// Optional feature macro: DECODE_DELAY_SLOT_PAIR_EN (hold branches until their delay slot can issue with them).
module decoder
  import decode_queue_pkg::*;
(
  input  logic [31:0]    instr_i,
  output decoded_instr_t dec_o
);
  always_comb begin
    dec_o                = '0;
    dec_o.rs             = instr_i[25:21];
    dec_o.rt             = instr_i[20:16];
    dec_o.rd             = instr_i[15:11];
    dec_o.imm            = instr_i[15:0];
    dec_o.op             = OP_INVALID;
    dec_o.is_controlflow = 1'b0;
    case (instr_i[31:26])
      6'h00: begin
        case (instr_i[5:0])
          6'h00: dec_o.op = OP_SLL;
          6'h08: begin
            dec_o.op             = OP_JR;
            dec_o.is_controlflow = 1'b1;
          end
          6'h21: dec_o.op = OP_ADDU;
          6'h23: dec_o.op = OP_SUBU;
          6'h24: dec_o.op = OP_AND;
          6'h25: dec_o.op = OP_OR;
          6'h2a: dec_o.op = OP_SLT;
          default: dec_o.op = OP_INVALID;
        endcase
      end
      6'h02: begin dec_o.op = OP_J;   dec_o.is_controlflow = 1'b1; end
      6'h03: begin dec_o.op = OP_JAL; dec_o.is_controlflow = 1'b1; end
      6'h04: begin dec_o.op = OP_BEQ; dec_o.is_controlflow = 1'b1; end
      6'h05: begin dec_o.op = OP_BNE; dec_o.is_controlflow = 1'b1; end
      6'h09: dec_o.op = OP_ADDIU;
      6'h23: dec_o.op = OP_LW;
      6'h2b: dec_o.op = OP_SW;
      default: dec_o.op = OP_INVALID;
    endcase
  end
endmodule

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
)(
  input  logic          clk,
  input  logic          rst,
  decode_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(FETCH_WIDTH + 1);

  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  decoded_instr_t mem_instr_q [DEPTH];
  logic [31:0]    mem_pc_q    [DEPTH];

  decoded_instr_t dec [FETCH_WIDTH];
  logic [NW-1:0]  n_in;
  logic           run;
  logic           accept;
  logic [PW-1:0]  rd_idx [ISSUE_WIDTH];
  logic           kill;

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_dec
    decoder u_dec (.instr_i(q.fetch_instr[i]), .dec_o(dec[i]));
  end

  // Only the unbroken run of valid slots from slot 0 is enqueued.
  always_comb begin
    n_in = '0;
    run  = 1'b1;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (run && q.fetch_valid[i]) n_in = NW'(i + 1);
      else                         run  = 1'b0;
    end
  end

  // Space is judged from the registered count; same-cycle dequeues do not help.
  assign q.fetch_ready = (count_q <= CW'(DEPTH - FETCH_WIDTH));
  assign q.count       = count_q;
  assign accept        = q.fetch_ready && (n_in != '0) && !q.flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (accept) tail_d = tail_q + PW'(n_in);
      head_d  = head_q + PW'(q.issue_num);
      count_d = count_q + (accept ? CW'(n_in) : '0) - CW'(q.issue_num);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (accept && (NW'(i) < n_in)) begin
        mem_instr_q[tail_q + PW'(i)] <= dec[i];
        mem_pc_q[tail_q + PW'(i)]    <= q.fetch_pc[i];
      end
    end
  end

  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_rd
    assign rd_idx[k]        = head_q + PW'(k);
    assign q.issue_instr[k] = mem_instr_q[rd_idx[k]];
    assign q.issue_pc[k]    = mem_pc_q[rd_idx[k]];
  end

  // Once a slot is invalid (absent or held) every higher slot is invalid too.
  always_comb begin
    q.issue_valid = '0;
    kill          = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (!kill && (CW'(k) < count_q)) begin
        q.issue_valid[k] = 1'b1;
`ifdef DECODE_DELAY_SLOT_PAIR_EN
        if (mem_instr_q[rd_idx[k]].is_controlflow &&
            ((CW'(k + 1) >= count_q) || ((ISSUE_WIDTH > 1) && (k == ISSUE_WIDTH - 1)))) begin
          q.issue_valid[k] = 1'b0;
          kill             = 1'b1;
        end
`endif
      end else begin
        kill = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: scoreboard of expected PCs/ops
// pushed on accepted fetch groups and popped when issue consumes them.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int FETCH_WIDTH = 2;
  localparam int ISSUE_WIDTH = 2;
  localparam int DEPTH       = 8;
  localparam int CW          = $clog2(DEPTH + 1);
  localparam int IW          = $clog2(ISSUE_WIDTH + 1);

  localparam logic [31:0] I_ADDU = 32'h0022_1821;  // addu $3,$1,$2
  localparam logic [31:0] I_OR   = 32'h0085_3025;  // or   $6,$4,$5
  localparam logic [31:0] I_SUBU = 32'h0022_1823;  // subu $3,$1,$2
  localparam logic [31:0] I_LW   = 32'h8C22_0004;  // lw   $2,4($1)
  localparam logic [31:0] I_BEQ  = 32'h1022_0003;  // beq  $1,$2,3
  localparam logic [31:0] I_NOP  = 32'h0000_0000;

  logic clk;
  logic rst;

  decode_queue_if #(.FETCH_WIDTH(FETCH_WIDTH), .ISSUE_WIDTH(ISSUE_WIDTH), .DEPTH(DEPTH)) dq_if ();

  decode_queue #(.FETCH_WIDTH(FETCH_WIDTH), .ISSUE_WIDTH(ISSUE_WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (dq_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [3:0]  exp_op_q[$];
  logic [31:0] ins_tab [4];
  logic [3:0]  op_tab  [4];
  int          m_count;
  logic [31:0] pc_next;
  logic [31:0] last_pc;
  int          n_vec;
  int          n_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dq_if.flush       = 1'b0;
    dq_if.fetch_valid = '0;
    dq_if.fetch_instr = '0;
    dq_if.fetch_pc    = '0;
    dq_if.issue_num   = '0;
  endtask

  // ---------------- driver ----------------
  // One cycle: check outputs against the model, consume n_issue, offer fv.
  task automatic drive_cycle(input logic [1:0] fv, input int n_issue, input logic fl);
    int          vis;
    int          n_in;
    int          n_pop;
    logic        acc;
    logic        rdy;
    logic [1:0]  exp_v;
    logic [31:0] e_pc;
    logic [3:0]  e_op;
    logic [3:0]  slot_op [2];
    int          sel;

    vis   = (m_count < ISSUE_WIDTH) ? m_count : ISSUE_WIDTH;
    exp_v = '0;
    for (int k = 0; k < vis; k++) exp_v[k] = 1'b1;
    rdy   = (DEPTH - m_count) >= FETCH_WIDTH;

    n_vec++;
    if (dq_if.count !== CW'(m_count)) begin
      n_err++;
      $display("FAIL count: got %0d expected %0d", dq_if.count, m_count);
    end
    n_vec++;
    if (dq_if.issue_valid !== exp_v) begin
      n_err++;
      $display("FAIL issue_valid: got %b expected %b", dq_if.issue_valid, exp_v);
    end
    n_vec++;
    if (dq_if.fetch_ready !== rdy) begin
      n_err++;
      $display("FAIL fetch_ready: got %b expected %b", dq_if.fetch_ready, rdy);
    end

    n_pop = 0;
    if (!fl) begin
      n_vec++;
      if (n_issue > vis) begin
        n_err++;
        $display("FAIL issue_num_legal: issue_num %0d exceeds %0d valid entries", n_issue, vis);
      end
      n_pop = (n_issue > vis) ? vis : n_issue;
      for (int k = 0; k < n_pop; k++) begin
        e_pc = exp_q.pop_front();
        e_op = exp_op_q.pop_front();
        n_vec++;
        if (dq_if.issue_pc[k] !== e_pc) begin
          n_err++;
          $display("FAIL issue_pc[%0d]: got %h expected %h", k, dq_if.issue_pc[k], e_pc);
        end
        n_vec++;
        if (dq_if.issue_instr[k].op !== e_op) begin
          n_err++;
          $display("FAIL issue_op[%0d]: got %0d expected %0d", k, dq_if.issue_instr[k].op, e_op);
        end
        n_vec++;
        if (!(dq_if.issue_pc[k] > last_pc)) begin
          n_err++;
          $display("FAIL pc_order: got %h after %h, required increasing", dq_if.issue_pc[k], last_pc);
        end
        last_pc = dq_if.issue_pc[k];
      end
    end

    dq_if.flush       = fl;
    dq_if.fetch_valid = fv;
    dq_if.issue_num   = IW'(n_issue);
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      sel                  = $urandom_range(0, 3);
      dq_if.fetch_instr[i] = ins_tab[sel];
      dq_if.fetch_pc[i]    = pc_next + 32'(4 * i);
      slot_op[i]           = op_tab[sel];
    end

    n_in = fv[0] ? (fv[1] ? 2 : 1) : 0;
    acc  = rdy && (n_in > 0) && !fl;
    if (acc) begin
      for (int i = 0; i < n_in; i++) begin
        exp_q.push_back(pc_next + 32'(4 * i));
        exp_op_q.push_back(slot_op[i]);
      end
    end
    pc_next = pc_next + 32'd8;

    if (fl) begin
      m_count = 0;
      exp_q.delete();
      exp_op_q.delete();
    end else begin
      m_count = m_count + (acc ? n_in : 0) - n_pop;
    end

    step();
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    n_vec++;
    if (dq_if.count !== '0) begin
      n_err++;
      $display("FAIL reset_count: got %0d expected 0", dq_if.count);
    end
    n_vec++;
    if (dq_if.fetch_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_fetch_ready: got %b expected 1", dq_if.fetch_ready);
    end
    n_vec++;
    if (dq_if.issue_valid !== '0) begin
      n_err++;
      $display("FAIL reset_issue_valid: got %b expected 00", dq_if.issue_valid);
    end
    rst = 1'b0;
    step();
    dq_if.fetch_valid    = 2'b11;
    dq_if.fetch_instr[0] = I_ADDU;
    dq_if.fetch_instr[1] = I_OR;
    dq_if.fetch_pc[0]    = 32'h100;
    dq_if.fetch_pc[1]    = 32'h104;
    exp_q.push_back(32'h100);    exp_op_q.push_back(OP_ADDU);
    exp_q.push_back(32'h104);    exp_op_q.push_back(OP_OR);
    m_count = 2;
    pc_next = 32'h108;
    step();
    idle_inputs();
    drive_cycle(2'b00, 2, 1'b0);
  endtask

  task automatic test_fill();
    for (int g = 0; g < 4; g++) drive_cycle(2'b11, 0, 1'b0);
    drive_cycle(2'b11, 0, 1'b0);  // full: refused
    drive_cycle(2'b11, 2, 1'b0);  // dequeue does not make room this cycle
    drive_cycle(2'b00, 2, 1'b0);
    drive_cycle(2'b00, 2, 1'b0);
    drive_cycle(2'b00, 2, 1'b0);
    drive_cycle(2'b00, 0, 1'b0);
  endtask

  task automatic test_wrap();
    drive_cycle(2'b11, 0, 1'b0);
    for (int c = 0; c < 20; c++) drive_cycle(2'b11, 2, 1'b0);
    drive_cycle(2'b00, 2, 1'b0);
    drive_cycle(2'b00, 0, 1'b0);
  endtask

  task automatic test_flush();
    drive_cycle(2'b11, 0, 1'b0);
    drive_cycle(2'b11, 0, 1'b0);
    drive_cycle(2'b01, 0, 1'b0);
    drive_cycle(2'b11, 1, 1'b1);  // count=5, flush drops queue and group
    drive_cycle(2'b11, 0, 1'b0);
    drive_cycle(2'b00, 2, 1'b0);
    drive_cycle(2'b00, 0, 1'b0);
  endtask

  task automatic test_partial_valid();
    drive_cycle(2'b10, 0, 1'b0);  // broken run: nothing taken
    drive_cycle(2'b01, 0, 1'b0);
    drive_cycle(2'b10, 0, 1'b0);
    drive_cycle(2'b00, 1, 1'b0);
    drive_cycle(2'b00, 0, 1'b0);
  endtask

  task automatic test_pairing();
    logic [1:0] exp_first;
`ifdef DECODE_DELAY_SLOT_PAIR_EN
    exp_first = 2'b01;
`else
    exp_first = 2'b11;
`endif
    dq_if.fetch_valid    = 2'b11;
    dq_if.fetch_instr[0] = I_ADDU;
    dq_if.fetch_instr[1] = I_BEQ;
    dq_if.fetch_pc[0]    = 32'h200;
    dq_if.fetch_pc[1]    = 32'h204;
    step();
    idle_inputs();
    n_vec++;
    if (dq_if.issue_valid !== exp_first) begin
      n_err++;
      $display("FAIL pair_hold_valid: got %b expected %b", dq_if.issue_valid, exp_first);
    end
    n_vec++;
    if (dq_if.issue_pc[0] !== 32'h200 || dq_if.issue_instr[0].op !== OP_ADDU) begin
      n_err++;
      $display("FAIL pair_slot0: got pc %h op %0d expected pc 200 op %0d",
               dq_if.issue_pc[0], dq_if.issue_instr[0].op, OP_ADDU);
    end
    dq_if.issue_num      = 2'd1;
    dq_if.fetch_valid    = 2'b01;
    dq_if.fetch_instr[0] = I_NOP;
    dq_if.fetch_pc[0]    = 32'h208;
    step();
    idle_inputs();
    n_vec++;
    if (dq_if.issue_valid !== 2'b11) begin
      n_err++;
      $display("FAIL pair_release_valid: got %b expected 11", dq_if.issue_valid);
    end
    n_vec++;
    if (dq_if.issue_instr[0].op !== OP_BEQ || dq_if.issue_pc[0] !== 32'h204) begin
      n_err++;
      $display("FAIL pair_branch_slot0: got op %0d pc %h expected op %0d pc 204",
               dq_if.issue_instr[0].op, dq_if.issue_pc[0], OP_BEQ);
    end
    n_vec++;
    if (dq_if.issue_pc[1] !== 32'h208 || dq_if.issue_instr[1].op !== OP_SLL) begin
      n_err++;
      $display("FAIL pair_delay_slot: got op %0d pc %h expected op %0d pc 208",
               dq_if.issue_instr[1].op, dq_if.issue_pc[1], OP_SLL);
    end
    dq_if.issue_num = 2'd2;
    step();
    idle_inputs();
    n_vec++;
    if (dq_if.count !== '0) begin
      n_err++;
      $display("FAIL pair_drain_count: got %0d expected 0", dq_if.count);
    end
    m_count = 0;
  endtask

  task automatic test_async_reset();
    drive_cycle(2'b11, 0, 1'b0);
    drive_cycle(2'b11, 0, 1'b0);
    #2;
    rst = 1'b1;  // mid-cycle, away from any clock edge
    #1;
    n_vec++;
    if (dq_if.count !== '0) begin
      n_err++;
      $display("FAIL async_reset_count: got %0d expected 0", dq_if.count);
    end
    n_vec++;
    if (dq_if.issue_valid !== '0) begin
      n_err++;
      $display("FAIL async_reset_valid: got %b expected 00", dq_if.issue_valid);
    end
    m_count = 0;
    exp_q.delete();
    exp_op_q.delete();
    dq_if.fetch_valid = 2'b11;  // must be ignored while in reset
    step();
    step();
    idle_inputs();
    rst = 1'b0;
    step();
    drive_cycle(2'b11, 0, 1'b0);
    drive_cycle(2'b00, 2, 1'b0);
    drive_cycle(2'b00, 0, 1'b0);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_count = 0;
    pc_next = 32'h100;
    last_pc = 32'h0;
    ins_tab[0] = I_ADDU;  op_tab[0] = OP_ADDU;
    ins_tab[1] = I_OR;    op_tab[1] = OP_OR;
    ins_tab[2] = I_SUBU;  op_tab[2] = OP_SUBU;
    ins_tab[3] = I_LW;    op_tab[3] = OP_LW;

    test_reset();
    test_fill();
    test_wrap();
    test_flush();
    test_partial_valid();
    test_pairing();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
